// File: rtl/sum_bcd_display_reader.sv
// Converts {carry,Z} to three BCD digits by shift-and-add-3 (load at edge k -> done in cycle k+IN_W+1)
// and scans them onto a 3-digit seven-segment display; load is ignored, not queued, while a conversion runs.
module sum_bcd_display_reader #(
   parameter int unsigned IN_W        = 7,
   parameter int unsigned REFRESH_W   = 16,
   parameter bit          SEG_ACT_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Z,
   input  logic       carry,
   input  logic       load,
   output logic       busy,
   output logic       done,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [6:0] seg,
   output logic [2:0] an
);

   localparam int unsigned CNT_W = $clog2(IN_W + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q;
   logic [IN_W-1:0]    shreg_q;
   logic [11:0]        bcd_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [3:0]         hund_q;
   logic [3:0]         tens_q;
   logic [3:0]         ones_q;

   logic [11:0]        bcd_adj;
   logic [11:0]        bcd_d;
   logic [IN_W-1:0]    shreg_d;

   // Add-3 correction first, then one left shift of {scratch, shreg}.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end
      end
      bcd_d   = {bcd_adj[10:0], shreg_q[IN_W-1]};
      shreg_d = {shreg_q[IN_W-2:0], 1'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hund_q  <= 4'd0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (load) begin
                  shreg_q <= IN_W'({carry, Z});
                  bcd_q   <= '0;
                  cnt_q   <= CNT_W'(IN_W);
                  busy_q  <= 1'b1;
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               shreg_q <= shreg_d;
               bcd_q   <= bcd_d;
               cnt_q   <= cnt_q - CNT_W'(1);
               // Last shift: publish the result in the same edge so done and digits align.
               if (cnt_q == CNT_W'(1)) begin
                  hund_q  <= bcd_d[11:8];
                  tens_q  <= bcd_d[7:4];
                  ones_q  <= bcd_d[3:0];
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hundreds = hund_q;
   assign tens     = tens_q;
   assign ones     = ones_q;

   function automatic logic [6:0] seg_pat(input logic [3:0] d);
      case (d)
         4'd0:    seg_pat = 7'h3F;
         4'd1:    seg_pat = 7'h06;
         4'd2:    seg_pat = 7'h5B;
         4'd3:    seg_pat = 7'h4F;
         4'd4:    seg_pat = 7'h66;
         4'd5:    seg_pat = 7'h6D;
         4'd6:    seg_pat = 7'h7D;
         4'd7:    seg_pat = 7'h07;
         4'd8:    seg_pat = 7'h7F;
         4'd9:    seg_pat = 7'h6F;
         default: seg_pat = 7'h00;
      endcase
   endfunction

   logic [REFRESH_W-1:0] refresh_q;
   logic [REFRESH_W-1:0] refresh_d;
   logic [1:0]           sel_q;
   logic [1:0]           sel_d;
   logic [6:0]           seg_q;
   logic [6:0]           seg_d;
   logic [2:0]           an_q;
   logic [2:0]           an_d;
   logic [3:0]           disp_digit;
   logic                 disp_blank;

   always_comb begin
      refresh_d = refresh_q + REFRESH_W'(1);
      sel_d     = sel_q;
      if (refresh_q == '1) begin
         case (sel_q)
            2'd0:    sel_d = 2'd1;
            2'd1:    sel_d = 2'd2;
            default: sel_d = 2'd0;
         endcase
      end

      case (sel_d)
         2'd1: begin
            disp_digit = tens_q;
            disp_blank = (hund_q == 4'd0) && (tens_q == 4'd0);
         end
         2'd2: begin
            disp_digit = hund_q;
            disp_blank = (hund_q == 4'd0);
         end
         default: begin
            disp_digit = ones_q;
            disp_blank = 1'b0;
         end
      endcase

      seg_d = disp_blank ? 7'h00 : seg_pat(disp_digit);
      an_d  = 3'b001 << sel_d;
      if (SEG_ACT_LOW) begin
         seg_d = ~seg_d;
         an_d  = ~an_d;
      end
   end

   // seg/an are registered from the next select so they always describe the same digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_q <= '0;
         sel_q     <= 2'd0;
         seg_q     <= SEG_ACT_LOW ? 7'h7F : 7'h00;
         an_q      <= SEG_ACT_LOW ? 3'b111 : 3'b000;
      end else begin
         refresh_q <= refresh_d;
         sel_q     <= sel_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule
